// File: rtl/nibble_serial_cla_adder.sv
// -----------------------------------------------------------------------------
// nibble_serial_cla_adder
//
// Multi-cycle wide adder. Operands of W = 4*NIBBLES bits are accepted through
// a valid/ready handshake, then added one nibble per clock through a 4-bit
// carry look-ahead slice with the inter-nibble carry held in a register. The
// assembled sum, carry-out and signed-overflow flag are offered through a
// second valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands presented
//   in_ready   block can accept operands (IDLE)
//   a, b       W-bit operands
//   c_in       carry into bit 0
//   out_valid  result available (DONE)
//   out_ready  consumer takes result
//   sum        registered sum, a + b + c_in mod 2^W
//   c_out      carry out of bit W-1
//   ovf        signed overflow (carry into MSB xor carry out of MSB)
// -----------------------------------------------------------------------------

// 4-bit carry look-ahead slice: flat look-ahead equations, no internal ripple.
module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c0,
    output logic [3:0] s,
    output logic       c3,
    output logic       c4
);
    logic [3:0] g;
    logic [3:0] p;
    logic       c1;
    logic       c2;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_gp
            assign g[gi] = a[gi] & b[gi];
            assign p[gi] = a[gi] ^ b[gi];
        end
    endgenerate

    assign c1 = g[0] | (p[0] & c0);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c0);
    assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c0);

    assign s = p ^ {c3, c2, c1, c0};
endmodule

module nibble_serial_cla_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 c_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 c_out,
    output logic                 ovf
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADD  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          c_out_q, c_out_d;
    logic          ovf_q, ovf_d;

    // Nibble views of the latched operands, selected by the running index.
    logic [3:0] a_nibs [NIBBLES];
    logic [3:0] b_nibs [NIBBLES];

    genvar gi;
    generate
        for (gi = 0; gi < NIBBLES; gi++) begin : g_nib
            assign a_nibs[gi] = a_q[4*gi +: 4];
            assign b_nibs[gi] = b_q[4*gi +: 4];
        end
    endgenerate

    logic [3:0] nib_a;
    logic [3:0] nib_b;
    logic [3:0] nib_s;
    logic       nib_c3;
    logic       nib_c4;
    logic       last_nib;

    assign nib_a    = a_nibs[idx_q];
    assign nib_b    = b_nibs[idx_q];
    assign last_nib = (idx_q == IW'(NIBBLES - 1));

    cla4 u_cla4 (
        .a  (nib_a),
        .b  (nib_b),
        .c0 (carry_q),
        .s  (nib_s),
        .c3 (nib_c3),
        .c4 (nib_c4)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = c_in;
                    idx_d   = '0;
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                for (int k = 0; k < NIBBLES; k++) begin
                    if (idx_q == IW'(k)) begin
                        sum_d[4*k +: 4] = nib_s;
                    end
                end
                carry_d = nib_c4;
                if (last_nib) begin
                    // Carry into the MSB is the slice's c3 on the top nibble.
                    c_out_d = nib_c4;
                    ovf_d   = nib_c3 ^ nib_c4;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    // Handshake outputs come straight from the state register.
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_nibble_serial_cla_adder.sv
// -----------------------------------------------------------------------------
// Bench for nibble_serial_cla_adder: a 16-bit instance checked every cycle
// against an arithmetic reference plus literal expectations, and a 4-bit
// instance checked with literal expectations only.
// -----------------------------------------------------------------------------
module tb_nibble_serial_cla_adder;
    localparam int N  = 4;
    localparam int W  = 4 * N;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, c_in, out_valid, out_ready, c_out, ovf;
    logic [W-1:0] a, b, sum;

    logic         in_valid1, in_ready1, c_in1, out_valid1, c_out1, ovf1;
    logic         out_ready1;
    logic [3:0]   a1, b1, sum1;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    nibble_serial_cla_adder #(.NIBBLES(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .c_out(c_out), .ovf(ovf)
    );

    nibble_serial_cla_adder #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .c_in(c_in1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .c_out(c_out1), .ovf(ovf1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Reference: {c_out, ovf, sum} from plain integer addition.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mc);
        logic [W:0]   full;
        logic [W-1:0] low;
        full = {1'b0, ma} + {1'b0, mb} + (W+1)'(mc);
        low  = {1'b0, ma[W-2:0]} + {1'b0, mb[W-2:0]} + W'(mc);
        return {full[W], low[W-1] ^ full[W], full[W-1:0]};
    endfunction

    // ---------------- compare process (16-bit instance) ----------------
    logic [W+1:0] exp_q[$];
    int           ncyc = 0;
    int           due  = 0;
    bit           busy = 0;
    bit           seen = 0;
    bit           late_flagged = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            busy = 0;
            seen = 0;
            check("rst_out_valid", 32'(out_valid), 32'd0);
        end else begin
            check("in_ready", 32'(in_ready), 32'(!busy));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    if (!seen) begin
                        check("latency_cycle", 32'(ncyc), 32'(due));
                        seen = 1;
                    end
                    check("sum", 32'(sum), 32'(exp_q[0][W-1:0]));
                    check("c_out", 32'(c_out), 32'(exp_q[0][W+1]));
                    check("ovf", 32'(ovf), 32'(exp_q[0][W]));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        busy = 0;
                        seen = 0;
                        late_flagged = 0;
                    end
                end
            end else if (exp_q.size() > 0 && ncyc >= due && !late_flagged) begin
                check("out_valid_late", 32'(out_valid), 32'd1);
                late_flagged = 1;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, c_in));
                due  = ncyc + N + 1;
                busy = 1;
            end
        end
        ncyc++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_neg(input string name, input bit want_ready);
        int t;
        t = 0;
        @(negedge clk);
        while ((want_ready ? in_ready : out_valid) !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check(name, 32'd0, 32'd1);
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                          input logic [W-1:0] es, input logic ec, input logic eo);
        @(posedge clk); #1;
        a = ta; b = tb_; c_in = tc; in_valid = 1'b1; out_ready = 1'b1;
        wait_neg("accept_timeout", 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_neg("done_timeout", 1'b0);
        check("lit_sum", 32'(sum), 32'(es));
        check("lit_c_out", 32'(c_out), 32'(ec));
        check("lit_ovf", 32'(ovf), 32'(eo));
        @(negedge clk);
        check("done_one_cycle", 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; out_ready = 1'b1;
        in_valid1 = 1'b0; a1 = '0; b1 = '0; c_in1 = 1'b0; out_ready1 = 1'b1;

        // Pin the reference model to hand-computed values.
        check("model_5555", 32'(model(16'h1234, 16'h4321, 1'b0)), 32'h05555);
        check("model_ffff", 32'(model(16'hFFFF, 16'h0001, 1'b0)), 32'h20000);
        check("model_7fff", 32'(model(16'h7FFF, 16'h0000, 1'b1)), 32'h18000);
        check("model_8000", 32'(model(16'h8000, 16'h8000, 1'b0)), 32'h30000);

        #12;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_flags", 32'({c_out, ovf, out_valid}), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        run_op(16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1);

        // Backpressure with new operands waiting at the input.
        @(posedge clk); #1;
        a = 16'h1111; b = 16'h2222; c_in = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        wait_neg("bp_accept_timeout", 1'b1);
        @(posedge clk); #1;
        a = 16'h0F0F; b = 16'h0101; c_in = 1'b1;
        wait_neg("bp_done_timeout", 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("bp_sum_stable", 32'(sum), 32'h3333);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_in_ready_after", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_neg("bp2_done_timeout", 1'b0);
        check("bp2_sum", 32'(sum), 32'h1011);
        @(negedge clk);

        // Reset during the second ADD cycle.
        @(posedge clk); #1;
        a = 16'h1234; b = 16'h1111; c_in = 1'b0; in_valid = 1'b1;
        wait_neg("rst_accept_timeout", 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_sum", 32'(sum), 32'd0);
        check("async_rst_flags", 32'({c_out, ovf, out_valid}), 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("no_out_after_rst", 32'(out_valid), 32'd0);

        // NIBBLES = 1 instance: registered 4-bit CLA, 1-cycle latency.
        @(posedge clk); #1;
        a1 = 4'hF; b1 = 4'h1; c_in1 = 1'b0; in_valid1 = 1'b1;
        @(negedge clk);
        check("n1_in_ready", 32'(in_ready1), 32'd1);
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        @(negedge clk);
        check("n1_add_cycle", 32'(out_valid1), 32'd0);
        @(negedge clk);
        check("n1_out_valid", 32'(out_valid1), 32'd1);
        check("n1_sum", 32'(sum1), 32'h0);
        check("n1_c_out", 32'(c_out1), 32'd1);
        check("n1_ovf", 32'(ovf1), 32'd0);
        @(negedge clk);
        check("n1_done_one_cycle", 32'(out_valid1), 32'd0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/nibble_serial_cla_adder.md
# nibble_serial_cla_adder

Multi-cycle wide adder that accepts two (4·NIBBLES)-bit operands and a carry-in through a valid/ready handshake. It processes the operands one 4-bit nibble per clock through an internal 4-bit carry look-ahead slice, carrying between nibbles in a register. The assembled sum, carry-out and signed-overflow flag are presented through a second valid/ready handshake. It sits downstream of operand sources and reuses the team's 4-bit CLA as its per-cycle datapath stage.

## Interface
- NIBBLES, 4, number of 4-bit slices; operand width W = 4·NIBBLES; legal range 1..16
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands presented
- in_ready  output  1  block can accept operands
- a  input  W  operand A (unsigned or two's complement)
- b  input  W  operand B
- c_in  input  1  carry into bit 0
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- sum  output  W  registered sum, a + b + c_in mod 2^W
- c_out  output  1  carry out of bit W-1
- ovf  output  1  signed overflow, carry into bit W-1 XOR carry out of bit W-1

## Operation
- State machine: IDLE, ADD, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, latch a, b and c_in into internal registers.
  - Clear nibble index to 0, load carry register with c_in, go to ADD.
- ADD (in_ready = 0):
  - Each cycle, nibble k = index feeds the CLA slice with the latched a[4k+3:4k], b[4k+3:4k] and the carry register.
  - CLA slice: g_i = a_i & b_i, p_i = a_i ^ b_i; c1..c4 from flat look-ahead equations in g, p and c0; s_i = p_i ^ c_i.
  - Write s into sum[4k+3:4k], carry register ← c4, index ← index + 1.
  - On the last nibble (index = NIBBLES-1): c_out ← c4, ovf ← c3 ^ c4, go to DONE.
  - Index width is ceil(log2(NIBBLES)), minimum 1 bit; it never wraps past NIBBLES-1.
- DONE:
  - out_valid = 1.
  - sum, c_out and ovf are stable while out_valid & !out_ready.
  - On out_valid & out_ready, go to IDLE.
- in_valid while not in IDLE is ignored; no data is captured.
- sum, c_out and ovf keep their last values after the DONE→IDLE handshake until the next computation overwrites them.
- During ADD, sum nibbles above index are not yet valid; consumers use sum only when out_valid = 1.
- Reset (asynchronous, any state, including mid-ADD):
  - state = IDLE, index = 0, carry register = 0, latched operands = 0.
  - sum = 0, c_out = 0, ovf = 0, out_valid = 0.
  - in_ready = 1 once rst_n is high.
  - An in-flight computation is discarded and never produces out_valid.

## Timing
- in_ready and out_valid are decoded from the state register only; there is no combinational path from inputs to outputs.
- Accept edge E0 → ADD for edges E1..E(NIBBLES) → out_valid high immediately after edge E(NIBBLES).
- Latency is NIBBLES cycles from accept to out_valid.
- Result handshake edge Ed → in_ready = 1 in the following cycle.
- Minimum initiation interval is NIBBLES + 2 cycles (accept, NIBBLES adds, 1 DONE cycle with out_ready = 1).
- out_ready held high continuously: DONE lasts exactly 1 cycle.
- NIBBLES = 1: a single ADD cycle, behaving as a registered 4-bit CLA with 1-cycle latency.

## Test plan
- NIBBLES=4, a=0x1234, b=0x4321, c_in=0, out_ready=1 → out_valid exactly 4 cycles after accept; sum=0x5555, c_out=0, ovf=0; out_valid high for 1 cycle.
- a=0xFFFF, b=0x0001, c_in=0 → sum=0x0000, c_out=1, ovf=0 (carry ripples through all four nibble registers).
- a=0x7FFF, b=0x0000, c_in=1 → sum=0x8000, c_out=0, ovf=1.
- a=0x8000, b=0x8000, c_in=0 → sum=0x0000, c_out=1, ovf=1.
- Backpressure: out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands:
  - out_valid, sum, c_out and ovf are stable and in_ready=0 throughout.
  - After out_ready=1, in_ready=1 the next cycle, and the new operands are accepted only then.
- Reset mid-ADD: rst_n low during the 2nd ADD cycle → out_valid, sum, c_out and ovf are 0 without waiting for a clock edge. After release, in_ready=1 and no out_valid appears for the discarded operation. Also cover NIBBLES=1 with 0xF+0x1, c_in=0 → sum=0x0, c_out=1, ovf=0, latency 1.
